// File: rtl/frame_buffer_pkg.sv
// Shared types and elaboration-time helpers for the overlapping-window framer.
package frame_pkg;

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        ADVANCE
    } state_e;

    localparam int depth_default = 32;
    localparam int ptr_w = $clog2(depth_default) + 1;

    // One extra pointer bit lets occupancy distinguish full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_ok(input int frame_len, input int hop, input int depth);
        return (hop >= 1) && (hop <= frame_len) && (depth >= frame_len + hop) &&
               ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/frame_buffer_counter.sv
// Free-running wrap-around counter; used as the framer's write pointer.
module counter
    import frame_pkg::*;
#(
    parameter int width_p = ptr_w
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if (en_i) begin
            count_o <= count_o + width_p'(1);
        end
    end

endmodule

// File: rtl/frame_buffer.sv
// Circular sample buffer replayed as fixed-length frames that overlap by
// frame_len_p - hop_p samples.
module frame_buffer
    import frame_pkg::*;
#(
    parameter int width_p     = 16,
    parameter int frame_len_p = 16,
    parameter int hop_p       = 8,
    parameter int depth_p     = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic signed [width_p-1:0] data_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic signed [width_p-1:0] data_o,
    output logic                      frame_start_o,
    output logic                      frame_last_o
);

    localparam int pw = ptr_width(depth_p);
    localparam int aw = pw - 1;
    localparam logic [pw-1:0] depth_c = pw'(depth_p);
    localparam logic [pw-1:0] frame_c = pw'(frame_len_p);
    localparam logic [pw-1:0] last_c  = pw'(frame_len_p - 1);
    localparam logic [pw-1:0] hop_c   = pw'(hop_p);

    if (!params_ok(frame_len_p, hop_p, depth_p)) begin : g_param_err
        $error("frame_buffer: illegal frame_len_p/hop_p/depth_p combination");
    end

    logic [pw-1:0] wr_cnt;
    logic [pw-1:0] base;
    logic [pw-1:0] rd_idx;
    logic [pw-1:0] rd_next;
    logic [pw-1:0] rd_addr_next;
    logic [pw-1:0] occ;
    logic          in_fire;
    state_e        state;

    logic signed [width_p-1:0] mem [depth_p];

    // Both pointers are registered, so occupancy never sees a write/advance race.
    assign occ          = wr_cnt - base;
    assign ready_o      = !reset_i && (occ < depth_c);
    assign in_fire      = valid_i && ready_o;
    assign rd_next      = rd_idx + pw'(1);
    assign rd_addr_next = base + rd_next;

    counter #(
        .width_p (pw)
    ) u_wr_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (in_fire),
        .count_o (wr_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            mem[wr_cnt[aw-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= FILL;
            base          <= '0;
            rd_idx        <= '0;
            valid_o       <= 1'b0;
            frame_start_o <= 1'b0;
            frame_last_o  <= 1'b0;
            data_o        <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (occ >= frame_c) begin
                        data_o        <= mem[base[aw-1:0]];
                        valid_o       <= 1'b1;
                        frame_start_o <= 1'b1;
                        frame_last_o  <= (last_c == '0);
                        rd_idx        <= '0;
                        state         <= EMIT;
                    end
                end
                EMIT: begin
                    if (valid_o && ready_i) begin
                        if (frame_last_o) begin
                            valid_o       <= 1'b0;
                            frame_start_o <= 1'b0;
                            frame_last_o  <= 1'b0;
                            state         <= ADVANCE;
                        end else begin
                            rd_idx        <= rd_next;
                            data_o        <= mem[rd_addr_next[aw-1:0]];
                            frame_start_o <= 1'b0;
                            frame_last_o  <= (rd_next == last_c);
                        end
                    end
                end
                ADVANCE: begin
                    base  <= base + hop_c;
                    state <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer.sv
// Self-checking bench for frame_buffer: reset table, scoreboarded frames and
// hand-written full/backpressure/reset sequences.
module tb_frame_buffer;

    localparam int W   = 16;
    localparam int FL  = 16;
    localparam int HOP = 8;
    localparam int D   = 32;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] data_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] data_o;
    logic         frame_start_o;
    logic         frame_last_o;

    always #5 clk_i = ~clk_i;

    frame_buffer #(
        .width_p     (W),
        .frame_len_p (FL),
        .hop_p       (HOP),
        .depth_p     (D)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_i        (data_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .data_o        (data_o),
        .frame_start_o (frame_start_o),
        .frame_last_o  (frame_last_o)
    );

    typedef struct {
        logic [W-1:0] d;
        bit           s;
        bit           l;
    } exp_t;

    typedef struct {
        bit           rst;
        bit           vin;
        bit           rdy;
        logic [W-1:0] din;
        bit           e_ready;
        bit           e_valid;
        logic [W-1:0] e_data;
    } vec_t;

    exp_t         exp_q[$];
    logic [W-1:0] in_hist[$];
    int           base_m;
    int           n_tests;
    int           n_fail;
    int           cyc;
    int           acc_cyc;
    int           frames_seen;
    int           low_cnt;
    bit           lat_chk;
    bit           gap_chk;
    bit           prev_valid;
    bit           prev_stall;
    logic [W-1:0] prev_d;
    bit           prev_s;
    bit           prev_l;
    logic [W-1:0] last_rise_d;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted sample is logged; each time a full
    // window is available its samples are queued as the expected frame.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (reset_i) begin
                in_hist.delete();
                exp_q.delete();
                base_m      = 0;
                prev_stall  = 0;
                prev_valid  = 0;
                frames_seen = 0;
                low_cnt     = 0;
                acc_cyc     = -100;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", valid_o, 1);
                    check("stall_data", data_o, prev_d);
                    check("stall_start", frame_start_o, prev_s);
                    check("stall_last", frame_last_o, prev_l);
                end
                if (valid_o && !prev_valid) begin
                    if (lat_chk && frames_seen == 0) check("first_latency", cyc - acc_cyc, 2);
                    if (gap_chk && frames_seen > 0) check("frame_gap", low_cnt, 2);
                    last_rise_d = data_o;
                    frames_seen++;
                end
                low_cnt = valid_o ? 0 : low_cnt + 1;
                if (valid_i && ready_o) begin
                    in_hist.push_back(data_i);
                    if (in_hist.size() == FL) acc_cyc = cyc;
                    while (in_hist.size() >= base_m + FL) begin
                        for (int k = 0; k < FL; k++) begin
                            e.d = in_hist[base_m + k];
                            e.s = (k == 0);
                            e.l = (k == FL - 1);
                            exp_q.push_back(e);
                        end
                        base_m += HOP;
                    end
                end
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL out_unexpected: got data %0d, expected no output", data_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", data_o, e.d);
                        check("out_start", frame_start_o, e.s);
                        check("out_last", frame_last_o, e.l);
                    end
                end
                prev_stall = valid_o && !ready_i;
                prev_d     = data_o;
                prev_s     = frame_start_o;
                prev_l     = frame_last_o;
                prev_valid = valid_o;
            end
        end
    endtask

    task automatic send(input logic [W-1:0] v, input int budget);
        bit ok;
        ok      = 0;
        valid_i = 1'b1;
        data_i  = v;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (ready_o) ok = 1;
            @(posedge clk_i);
            #1;
            if (ok) break;
        end
        valid_i = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic do_reset(input int n);
        reset_i = 1'b1;
        valid_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !valid_o) break;
            @(posedge clk_i);
            #1;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   v;
        int   rise_t;
        int   waited;

        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        lat_chk = 0;
        gap_chk = 0;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;

        fork
            monitor();
        join_none

        tbl[0] = '{1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000};

        @(posedge clk_i);
        #1;
        for (int i = 0; i < 4; i++) begin
            reset_i = tbl[i].rst;
            valid_i = tbl[i].vin;
            ready_i = tbl[i].rdy;
            data_i  = tbl[i].din;
            @(negedge clk_i);
            check("rst_ready_o", ready_o, tbl[i].e_ready);
            check("rst_valid_o", valid_o, tbl[i].e_valid);
            check("rst_data_o", data_o, tbl[i].e_data);
            check("rst_start_o", frame_start_o, 0);
            check("rst_last_o", frame_last_o, 0);
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;

        // Overlap, first-frame latency and inter-frame gap.
        ready_i = 1'b1;
        lat_chk = 1;
        gap_chk = 1;
        for (int i = 0; i < 40; i++) send(W'(i), 60);
        drain(200);
        check("overlap_frames", frames_seen, 4);
        lat_chk = 0;
        gap_chk = 0;

        // Full buffer with output blocked.
        do_reset(3);
        ready_i = 1'b0;
        v       = 0;
        valid_i = 1'b1;
        data_i  = W'(v);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (ready_o) v++;
            @(posedge clk_i);
            #1;
            data_i = W'(v);
        end
        check("full_accepted", v, 32);
        @(negedge clk_i);
        check("full_ready_o", ready_o, 0);
        check("full_data_o", data_o, 0);
        check("full_valid_o", valid_o, 1);
        check("full_start_o", frame_start_o, 1);
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        rise_t  = -1;
        for (int t = 0; t < 200 && v < 40; t++) begin
            @(negedge clk_i);
            if (ready_o) begin
                if (v == 32) rise_t = t;
                v++;
            end
            @(posedge clk_i);
            #1;
            data_i = W'(v);
        end
        valid_i = 1'b0;
        check("full_ready_rise", rise_t, 17);
        drain(300);
        check("full_frames", frames_seen, 4);

        // Random output backpressure.
        do_reset(3);
        fork
            begin
                for (int i = 0; i < 40; i++) send(W'(1000 + i), 200);
            end
            begin
                repeat (300) begin
                    ready_i = 1'($urandom_range(0, 1));
                    @(posedge clk_i);
                    #1;
                end
                ready_i = 1'b1;
            end
        join
        drain(300);
        check("bp_frames", frames_seen, 4);

        // Reset in the middle of frame 1.
        do_reset(3);
        ready_i = 1'b1;
        for (int i = 0; i < 24; i++) send(W'(500 + i), 60);
        waited = 0;
        while (frames_seen < 2 && waited < 100) begin
            @(posedge clk_i);
            #1;
            waited++;
        end
        check("mid_frame1_seen", frames_seen, 2);
        repeat (3) @(posedge clk_i);
        #1;
        do_reset(2);
        for (int i = 0; i < 16; i++) send(W'(700 + i), 60);
        drain(200);
        check("post_reset_frames", frames_seen, 1);
        check("post_reset_first", last_rise_d, 700);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
